// File: rtl/q_grid_pkg.sv
// Shared constants and types for the 5x5 grid-world Q-learning datapath.
package q_grid_pkg;

  localparam int unsigned STATES_WIDTH  = 5;
  localparam int unsigned ACTIONS_WIDTH = 2;
  localparam int unsigned STEP_WIDTH    = 8;
  localparam int unsigned NUM_STATES    = 25;
  localparam int unsigned GRID_W        = 5;

  localparam logic [STATES_WIDTH-1:0] GOAL_STATE = STATES_WIDTH'(24);

  localparam logic [ACTIONS_WIDTH-1:0] ACT_UP    = 2'b00;
  localparam logic [ACTIONS_WIDTH-1:0] ACT_DOWN  = 2'b01;
  localparam logic [ACTIONS_WIDTH-1:0] ACT_RIGHT = 2'b10;
  localparam logic [ACTIONS_WIDTH-1:0] ACT_LEFT  = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/grid_action_decode.sv
// Combinational inverse of the grid next-state function: (prev, cur) -> action.
module grid_action_decode
  import q_grid_pkg::*;
(
  input  logic [STATES_WIDTH-1:0]  prev,
  input  logic [STATES_WIDTH-1:0]  cur,
  output logic [ACTIONS_WIDTH-1:0] at,
  output logic                     blocked,
  output logic                     illegal
);

  localparam logic [STATES_WIDTH-1:0] N_ST     = STATES_WIDTH'(NUM_STATES);
  localparam logic [STATES_WIDTH-1:0] ROW_STEP = STATES_WIDTH'(GRID_W);
  localparam logic [STATES_WIDTH-1:0] LAST_ROW = STATES_WIDTH'(NUM_STATES - GRID_W);
  localparam logic [STATES_WIDTH-1:0] ONE      = STATES_WIDTH'(1);
  localparam logic [2:0]              LAST_COL = 3'(GRID_W - 1);

  logic [2:0] col;

  // Column of the previous state within its row.
  always_comb begin
    col = 3'(prev % ROW_STEP);
  end

  // Priority decode: real moves first, then the column-0 wrap to state 0, then walls.
  always_comb begin
    at      = ACT_UP;
    blocked = 1'b0;
    illegal = 1'b0;
    if (prev >= N_ST || cur >= N_ST) begin
      illegal = 1'b1;
    end else if (prev >= ROW_STEP && cur == prev - ROW_STEP) begin
      at = ACT_UP;
    end else if (prev < LAST_ROW && cur == prev + ROW_STEP) begin
      at = ACT_DOWN;
    end else if (col != LAST_COL && cur == prev + ONE) begin
      at = ACT_RIGHT;
    end else if (col != 3'd0 && cur == prev - ONE) begin
      at = ACT_LEFT;
    end else if (cur == '0 && col == 3'd0 && prev != '0) begin
      at = ACT_LEFT;
    end else if (cur == prev) begin
      blocked = 1'b1;
      if (prev < ROW_STEP) begin
        at = ACT_UP;
      end else if (prev >= LAST_ROW) begin
        at = ACT_DOWN;
      end else if (col == LAST_COL) begin
        at = ACT_RIGHT;
      end else if (prev == '0) begin
        // Shadowed by the top-row case; retained so every wall is named.
        at = ACT_LEFT;
      end else begin
        blocked = 1'b0;
        illegal = 1'b1;
      end
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/grid_transition_decoder.sv
// Recovers the agent's action from consecutive grid states; single output register stage.
module grid_transition_decoder
  import q_grid_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [STATES_WIDTH-1:0]  i_st,
  input  logic                     i_start,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [STATES_WIDTH-1:0]  o_prev_st,
  output logic [STATES_WIDTH-1:0]  o_next_st,
  output logic [ACTIONS_WIDTH-1:0] o_at,
  output logic                     o_blocked,
  output logic                     o_illegal,
  output logic                     o_goal,
  output logic [STEP_WIDTH-1:0]    o_step_cnt
);

  fsm_state_t                 state;
  logic [STATES_WIDTH-1:0]    prev;
  logic [STEP_WIDTH-1:0]      step;
  logic [STEP_WIDTH-1:0]      step_next;
  logic                       accept;
  logic                       is_goal;
  logic [ACTIONS_WIDTH-1:0]   dec_at;
  logic                       dec_blocked;
  logic                       dec_illegal;

  // Output register may be refilled whenever it is empty or draining this cycle.
  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign is_goal = (i_st == GOAL_STATE);

  // Saturating episode step count.
  always_comb begin
    step_next = (step == '1) ? step : step + STEP_WIDTH'(1);
  end

  grid_action_decode u_decode (
    .prev    (prev),
    .cur     (i_st),
    .at      (dec_at),
    .blocked (dec_blocked),
    .illegal (dec_illegal)
  );

  // Episode FSM, previous-state/step tracking and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      prev       <= '0;
      step       <= '0;
      o_valid    <= 1'b0;
      o_prev_st  <= '0;
      o_next_st  <= '0;
      o_at       <= '0;
      o_blocked  <= 1'b0;
      o_illegal  <= 1'b0;
      o_goal     <= 1'b0;
      o_step_cnt <= '0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (accept) begin
        prev <= i_st;
        case (state)
          ST_IDLE: begin
            step  <= '0;
            state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (i_start) begin
              step <= '0;
            end else begin
              step       <= step_next;
              o_valid    <= 1'b1;
              o_prev_st  <= prev;
              o_next_st  <= i_st;
              o_at       <= dec_at;
              o_blocked  <= dec_blocked;
              o_illegal  <= dec_illegal;
              o_goal     <= is_goal;
              o_step_cnt <= step_next;
              if (is_goal) begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grid_transition_decoder.sv
// Directed + randomized bench for grid_transition_decoder against a grid-world reference model.
module tb_grid_transition_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [4:0] i_st;
  logic       i_start;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_prev_st;
  logic [4:0] o_next_st;
  logic [1:0] o_at;
  logic       o_blocked;
  logic       o_illegal;
  logic       o_goal;
  logic [7:0] o_step_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_active;
  int m_prev;
  int m_step;
  bit e_valid;
  int e_prev, e_next, e_at, e_step;
  bit e_blk, e_ill, e_goal;
  int last_st;

  grid_transition_decoder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_st       (i_st),
    .i_start    (i_start),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_prev_st  (o_prev_st),
    .o_next_st  (o_next_st),
    .o_at       (o_at),
    .o_blocked  (o_blocked),
    .o_illegal  (o_illegal),
    .o_goal     (o_goal),
    .o_step_cnt (o_step_cnt)
  );

  always #5 clk = ~clk;

  // Forward grid dynamics: 0 Up, 1 Down, 2 Right, 3 Left (Left from column 0 lands on 0).
  function automatic int next_of(input int p, input int a);
    int r = p / 5;
    int c = p % 5;
    case (a)
      0:       return (r > 0) ? p - 5 : p;
      1:       return (r < 4) ? p + 5 : p;
      2:       return (c < 4) ? p + 1 : p;
      default: return (c > 0) ? p - 1 : 0;
    endcase
  endfunction

  // Inverse by search: first action (in Up, Down, Right, Left order) reaching q.
  function automatic void ref_decode(input int p, input int q,
                                     output int at, output bit blk, output bit ill);
    at = 0; blk = 1'b0; ill = 1'b1;
    if (p < 25 && q < 25) begin
      for (int a = 0; a < 4; a++) begin
        if (ill && next_of(p, a) == q) begin
          at  = a;
          ill = 1'b0;
          blk = (q == p);
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_prev = 0; m_step = 0;
    e_valid = 1'b0; e_prev = 0; e_next = 0; e_at = 0; e_step = 0;
    e_blk = 1'b0; e_ill = 1'b0; e_goal = 1'b0;
  endtask

  task automatic chk_model_out();
    chk("o_valid", 32'(o_valid), 32'(e_valid));
    if (e_valid) begin
      chk("o_prev_st",  32'(o_prev_st),  32'(e_prev));
      chk("o_next_st",  32'(o_next_st),  32'(e_next));
      chk("o_at",       32'(o_at),       32'(e_at));
      chk("o_blocked",  32'(o_blocked),  32'(e_blk));
      chk("o_illegal",  32'(o_illegal),  32'(e_ill));
      chk("o_goal",     32'(o_goal),     32'(e_goal));
      chk("o_step_cnt", 32'(o_step_cnt), 32'(e_step));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_prev"},  32'(o_prev_st), 0);
    chk({tag, "_next"},  32'(o_next_st), 0);
    chk({tag, "_at"},    32'(o_at), 0);
    chk({tag, "_flags"}, 32'({o_blocked, o_illegal, o_goal}), 0);
    chk({tag, "_step"},  32'(o_step_cnt), 0);
    chk({tag, "_ready"}, 32'(o_ready), 1);
  endtask

  // One clock: drive at negedge, check o_ready, then check the registered outputs after the edge.
  task automatic cycle(input bit v, input int st, input bit start, input bit rdy);
    bit ready, acc, blk, ill;
    int a;
    @(negedge clk);
    i_valid = v; i_st = 5'(st); i_start = start; i_ready = rdy;
    if (v) last_st = st;
    #1;
    ready = !e_valid || rdy;
    chk("o_ready", 32'(o_ready), 32'(ready));
    acc = v && ready;
    @(posedge clk);
    #1;
    if (e_valid && rdy) e_valid = 1'b0;
    if (acc) begin
      if (!m_active) begin
        m_active = 1'b1; m_prev = st; m_step = 0;
      end else if (start) begin
        m_prev = st; m_step = 0;
      end else begin
        ref_decode(m_prev, st, a, blk, ill);
        m_step  = (m_step < 255) ? m_step + 1 : 255;
        e_valid = 1'b1; e_prev = m_prev; e_next = st; e_at = a;
        e_blk = blk; e_ill = ill; e_goal = (st == 24); e_step = m_step;
        m_prev = st;
        if (st == 24) m_active = 1'b0;
      end
    end
    chk_model_out();
  endtask

  // Literal expectations for the hand-worked transitions.
  task automatic exp_tr(input string tag, input int p, input int n, input int at,
                        input int blk, input int ill, input int goal, input int step);
    chk({tag, "_v"},    32'(o_valid), 1);
    chk({tag, "_pn"},   32'({o_prev_st, o_next_st}), 32'((p << 5) | n));
    chk({tag, "_at"},   32'(o_at), 32'(at));
    chk({tag, "_big"},  32'({o_blocked, o_illegal, o_goal}), 32'((blk << 2) | (ill << 1) | goal));
    chk({tag, "_step"}, 32'(o_step_cnt), 32'(step));
  endtask

  initial begin
    int st;
    rst_n = 1'b0; i_valid = 1'b0; i_st = '0; i_start = 1'b0; i_ready = 1'b1;
    last_st = 0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic episode
    cycle(1, 7, 0, 1);
    chk("first_no_out", 32'(o_valid), 0);
    cycle(1, 12, 0, 1); exp_tr("t1a", 7, 12, 1, 0, 0, 0, 1);
    cycle(1, 13, 0, 1); exp_tr("t1b", 12, 13, 2, 0, 0, 0, 2);
    cycle(1, 14, 0, 1); exp_tr("t1c", 13, 14, 2, 0, 0, 0, 3);

    // Column-0 wrap, priority and walls
    cycle(1, 10, 1, 1);
    chk("restart_no_out", 32'(o_valid), 0);
    cycle(1, 0, 0, 1);  exp_tr("t2_10_0", 10, 0, 3, 0, 0, 0, 1);
    cycle(1, 5, 1, 1);
    cycle(1, 0, 0, 1);  exp_tr("t2_5_0", 5, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 1);  exp_tr("t2_0_0", 0, 0, 0, 1, 0, 0, 2);
    cycle(1, 9, 1, 1);
    cycle(1, 9, 0, 1);  exp_tr("t2_9_9", 9, 9, 2, 1, 0, 0, 1);

    // Illegal pairs
    cycle(1, 6, 1, 1);
    cycle(1, 18, 0, 1); exp_tr("t3_6_18", 6, 18, 0, 0, 1, 0, 1);
    cycle(1, 3, 1, 1);
    cycle(1, 26, 0, 1); exp_tr("t3_3_26", 3, 26, 0, 0, 1, 0, 1);

    // Goal ends the episode
    cycle(1, 19, 1, 1);
    cycle(1, 24, 0, 1); exp_tr("t4_goal", 19, 24, 1, 0, 0, 1, 1);
    cycle(1, 23, 0, 1);
    chk("after_goal_no_out", 32'(o_valid), 0);
    cycle(1, 22, 0, 1); exp_tr("t4_23_22", 23, 22, 3, 0, 0, 0, 1);

    // Backpressure
    cycle(1, 7, 1, 1);
    cycle(1, 12, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 17, 0, 0);
      exp_tr("t5_hold", 7, 12, 1, 0, 0, 0, 1);
    end
    cycle(1, 17, 0, 1); exp_tr("t5_release", 12, 17, 1, 0, 0, 0, 2);
    cycle(0, 0, 0, 1);
    chk("t5_drained", 32'(o_valid), 0);

    // Mid-episode restart, then asynchronous reset with a pending output
    cycle(1, 3, 1, 1);
    chk("t6_restart", 32'(o_valid), 0);
    cycle(1, 8, 0, 1);  exp_tr("t6_after_restart", 3, 8, 1, 0, 0, 0, 1);
    cycle(1, 13, 0, 0);
    chk("t6_pending", 32'(o_valid), 1);
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Step counter saturation over a long episode
    cycle(1, 0, 0, 1);
    for (int k = 0; k < 260; k++) cycle(1, (k % 2 == 0) ? 1 : 0, 0, 1);
    chk("step_saturated", 32'(o_step_cnt), 255);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0:       st = last_st - 5;
          1:       st = last_st + 5;
          2:       st = last_st + 1;
          3:       st = last_st - 1;
          default: st = last_st;
        endcase
        if (st < 0) st = 0;
        if (st > 31) st = 31;
      end else begin
        st = $urandom_range(0, 31);
      end
      cycle($urandom_range(0, 3) != 0, st, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grid_transition_decoder.md
# grid_transition_decoder

Recovers the action taken by the Q-learning agent from a stream of observed 5x5 grid-world states. It is the inverse of the next-state function. The block sits between the environment/state-trace source and the Q-table update logic. For every consecutive state pair (s, s') it emits the action a that the next-state function maps (s, a) to s', plus blocked/illegal/goal flags and a per-episode step count. Input and output use a valid/ready handshake with a single output register stage.

## Interface
- STATES_WIDTH, 5, state index width (states 0..24, row-major, 5 per row)
- ACTIONS_WIDTH, 2, action width (00 Up, 01 Down, 10 Right, 11 Left)
- GOAL_STATE, 24, terminal state; ends the episode
- STEP_WIDTH, 8, step counter width
- Clock and reset: one clock, `i_clk`; reset `i_rst_n` is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input state sample valid
- o_ready  out  1  block accepts sample; equals !o_valid || i_ready
- i_st  in  STATES_WIDTH  observed state
- i_start  in  1  sample is the first state of a new episode (qualified by accept)
- o_valid  out  1  decoded transition valid
- i_ready  in  1  downstream accepts transition
- o_prev_st  out  STATES_WIDTH  s
- o_next_st  out  STATES_WIDTH  s'
- o_at  out  ACTIONS_WIDTH  decoded action
- o_blocked  out  1  s'==s caused by a wall
- o_illegal  out  1  no action maps s to s'; o_at=00
- o_goal  out  1  s'==GOAL_STATE
- o_step_cnt  out  STEP_WIDTH  steps in the episode including this one

## Operation
- accept = i_valid && o_ready.
- **FSM IDLE:** no previous state is held.
  - On accept: prev<=i_st, step<=0, go to ACTIVE. No output is produced.
- **FSM ACTIVE:**
  - On accept with i_start=1: restart. prev<=i_st, step<=0, no output.
  - On accept with i_start=0: decode (prev, i_st), load the output register, set o_valid=1, prev<=i_st, step<=step+1 (saturating at all-ones), o_step_cnt=new step.
  - If i_st==GOAL_STATE: o_goal=1 and the FSM goes to IDLE.
- **Decode priority, first match wins** (col = prev mod 5):
  - Up: prev>=5 and s'==prev-5.
  - Down: prev<=19 and s'==prev+5.
  - Right: col!=4 and s'==prev+1.
  - Left: col!=0 and s'==prev-1.
  - Left: s'==0 and prev in {5,10,15,20}. This is the column-0 Left move to state 0. Note 5->0 decodes as Up, by priority.
  - Blocked (s'==prev, o_blocked=1):
    - Up if prev<5
    - else Down if prev>=20
    - else Right if col==4
    - else Left if prev==0 (unreachable after the Up case; kept for completeness)
  - Otherwise: o_illegal=1, o_at=00.
  - Any s or s' >=25: o_illegal=1.
- o_illegal and o_blocked are mutually exclusive.

## Timing
- Reset values: o_valid=0, every data/flag output=0, o_step_cnt=0, FSM=IDLE, prev=0. o_ready=1 after reset.
- Latency: one cycle from accept of s' to o_valid=1.
- Throughput: one transition per cycle when i_ready=1.
- Backpressure: while o_valid && !i_ready, all outputs are held stable and o_ready=0.
- Accept with i_ready=1 and o_valid=1: the output register is replaced in the same cycle (pass-through pipeline).
- The output register clears o_valid on handshake when no new accept occurs.
- The first sample after reset or after the goal produces no output, regardless of i_start.
- Reset mid-operation: a pending output is discarded and the FSM returns to IDLE asynchronously.

## Structure
- Shared package q_grid_pkg holds:
  - STATES_WIDTH, ACTIONS_WIDTH, NUM_STATES=25, GRID_W=5
  - action constants ACT_UP/ACT_DOWN/ACT_RIGHT/ACT_LEFT
  - the FSM state enum
- Submodule grid_action_decode: purely combinational. Takes (prev, cur) and returns (at, blocked, illegal).
- The top level holds the FSM, the prev register, the step counter and the output register.

## Test plan
1. Reset, then feed 7,12,13,14 with i_ready=1 -> three outputs: (7,12,Down,step1), (12,13,Right,step2), (13,14,Right,step3); flags 0.
2. Pairs 10->0, 5->0, 0->0, 9->9 -> Left; Up; Blocked Up; Blocked Right. Each with o_illegal=0.
3. Pairs 6->18 and 3->26 -> o_illegal=1, o_at=00, o_blocked=0.
4. Feed 19 then 24 -> output (19,24,Down,o_goal=1). A following sample 23 produces no output; a further 22 produces (23,22,Left,step1).
5. Hold i_ready=0 after the first output -> o_ready=0, outputs stable for 5 cycles. Release -> the next sample is accepted in the same cycle, with no loss or duplication.
6. Assert i_start on state 3 mid-episode, then assert i_rst_n=0 while o_valid=1 -> i_start restarts with no output and step count 0. Reset clears o_valid immediately and all outputs read 0.
